// File: rtl/mmu_pkg.sv
// Shared MMU types and constants used by the second-level TLB and its neighbours.
package mmu_pkg;

    localparam int unsigned LEVELS                = 3;
    localparam int unsigned PAGE_LVL_BITS         = 9;
    localparam int unsigned VPN_SIZE              = 27;
    localparam int unsigned PPN_SIZE              = 44;
    localparam int unsigned LEVEL_W               = $clog2(LEVELS);
    localparam int unsigned ASID_W                = 16;
    localparam int unsigned L2TLB_ENTRIES_DEFAULT = 16;

    typedef struct packed {
        logic [PPN_SIZE-1:0] ppn;
        logic [1:0]          rsw;
        logic                d;
        logic                a;
        logic                g;
        logic                u;
        logic                x;
        logic                w;
        logic                r;
        logic                v;
    } pte_t;

    typedef struct packed {
        logic                valid;
        logic [VPN_SIZE-1:0] vpn;
    } tlb_req_t;

    typedef struct packed {
        tlb_req_t req;
    } tlb_ptw_comm_t;

    typedef struct packed {
        logic               valid;
        logic               error;
        logic [LEVEL_W-1:0] level;
        pte_t               pte;
    } ptw_resp_t;

    typedef struct packed {
        logic [1:0]        prv;
        logic              sum;
        logic              mxr;
        logic [ASID_W-1:0] asid;
    } ptw_status_t;

    typedef struct packed {
        ptw_resp_t   resp;
        logic        ptw_ready;
        ptw_status_t ptw_status;
        logic        invalidate_tlb;
    } ptw_tlb_comm_t;

    typedef struct packed {
        logic                valid;
        logic [VPN_SIZE-1:0] vpn;
        logic [LEVEL_W-1:0]  level;
        pte_t                pte;
    } l2tlb_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_RESP
    } l2tlb_state_e;

    // Mask of the vpn bits that fall inside the page offset of a leaf at this level.
    function automatic logic [VPN_SIZE-1:0] low_mask(input logic [LEVEL_W-1:0] level);
        logic [VPN_SIZE-1:0] m;
        m = '0;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            if (LEVEL_W'(l) == level) begin
                m = (VPN_SIZE'(1) << ((LEVELS - l - 1) * PAGE_LVL_BITS)) - VPN_SIZE'(1);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pseudoLRU.sv
// Tree pseudo-LRU replacement state for a power-of-two set of entries.
module pseudoLRU #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       access_valid_i,
    input  logic [$clog2(ENTRIES)-1:0] access_idx_i,
    output logic [$clog2(ENTRIES)-1:0] victim_c
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    // Heap-ordered tree nodes 1..ENTRIES-1; a node bit of 1 steers the victim walk right.
    logic [ENTRIES-1:1] tree_q;
    logic [ENTRIES-1:1] tree_d;
    logic [IDX_W-1:0]   vic_node;
    logic [IDX_W-1:0]   upd_node;
    logic [IDX_W-1:0]   upd_idx;

    always_comb begin
        victim_c = '0;
        vic_node = IDX_W'(1);
        for (int unsigned l = 0; l < IDX_W; l++) begin
            victim_c = (victim_c << 1) | IDX_W'(tree_q[vic_node]);
            vic_node = (vic_node << 1) | IDX_W'(tree_q[vic_node]);
        end
    end

    // Point every node on the accessed path away from it.
    always_comb begin
        tree_d   = tree_q;
        upd_node = IDX_W'(1);
        upd_idx  = access_idx_i;
        if (access_valid_i) begin
            for (int unsigned l = 0; l < IDX_W; l++) begin
                tree_d[upd_node] = ~upd_idx[IDX_W-1];
                upd_node         = (upd_node << 1) | IDX_W'(upd_idx[IDX_W-1]);
                upd_idx          = upd_idx << 1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tree_q <= '0;
        end else begin
            tree_q <= tree_d;
        end
    end

endmodule

// File: rtl/l2_tlb.sv
// Shared fully-associative second-level TLB between the TLB arbiter and the page-table walker.
// Define L2TLB_PLRU_EN to use pseudo-LRU replacement instead of a round-robin pointer.
module l2_tlb
    import mmu_pkg::*;
#(
    parameter int unsigned L2TLB_ENTRIES = L2TLB_ENTRIES_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  tlb_ptw_comm_t tlb_ptw_comm_i,
    output ptw_tlb_comm_t ptw_tlb_comm_o,
    output tlb_ptw_comm_t tlb_ptw_comm_o,
    input  ptw_tlb_comm_t ptw_tlb_comm_i,
    output logic          pmu_l2tlb_hit_o,
    output logic          pmu_l2tlb_miss_o
);

    localparam int unsigned IDX_W = $clog2(L2TLB_ENTRIES);

    l2tlb_state_e        state_q;
    l2tlb_state_e        state_d;
    l2tlb_entry_t        entries_q [L2TLB_ENTRIES];
    logic [VPN_SIZE-1:0] req_vpn_q;
    logic                resp_error_q;
    logic [LEVEL_W-1:0]  resp_level_q;
    pte_t                resp_pte_q;
    logic                flush_pending_q;
    logic                hit_pulse_q;
    logic                miss_pulse_q;

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    pte_t                hit_pte;
    logic                free;
    logic [IDX_W-1:0]    free_idx;
    logic [IDX_W-1:0]    repl_idx;
    logic [IDX_W-1:0]    victim_idx;
    logic                accept;
    logic                lookup_hit;
    logic                handshake;
    logic                resp_take;
    logic                flush;
    logic                fill;
    l2tlb_entry_t        fill_entry;

    assign flush      = ptw_tlb_comm_i.invalidate_tlb;
    assign accept     = (state_q == S_IDLE) && tlb_ptw_comm_i.req.valid;
    assign lookup_hit = (state_q == S_LOOKUP) && hit;
    assign handshake  = (state_q == S_MISS_REQ) && ptw_tlb_comm_i.ptw_ready;
    assign resp_take  = (state_q == S_MISS_WAIT) && ptw_tlb_comm_i.resp.valid;
    assign fill       = resp_take && !ptw_tlb_comm_i.resp.error && !flush_pending_q && !flush;

    // Lowest matching entry wins; superpage entries ignore their page-offset vpn bits.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < L2TLB_ENTRIES; i++) begin
            if (!hit && entries_q[i].valid &&
                (((entries_q[i].vpn ^ req_vpn_q) & ~low_mask(entries_q[i].level)) == '0)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        hit_pte     = entries_q[hit_idx].pte;
        hit_pte.ppn = hit_pte.ppn | PPN_SIZE'(req_vpn_q & low_mask(entries_q[hit_idx].level));
    end

    always_comb begin
        free     = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < L2TLB_ENTRIES; i++) begin
            if (!free && !entries_q[i].valid) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign victim_idx = free ? free_idx : repl_idx;

    always_comb begin
        fill_entry         = '0;
        fill_entry.valid   = 1'b1;
        fill_entry.vpn     = req_vpn_q;
        fill_entry.level   = ptw_tlb_comm_i.resp.level;
        fill_entry.pte     = ptw_tlb_comm_i.resp.pte;
        fill_entry.pte.ppn = ptw_tlb_comm_i.resp.pte.ppn
                             & ~PPN_SIZE'(low_mask(ptw_tlb_comm_i.resp.level));
    end

`ifdef L2TLB_PLRU_EN
    logic             plru_access;
    logic [IDX_W-1:0] plru_idx;

    assign plru_access = lookup_hit || fill;
    assign plru_idx    = fill ? victim_idx : hit_idx;

    pseudoLRU #(
        .ENTRIES(L2TLB_ENTRIES)
    ) u_plru (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .access_valid_i (plru_access),
        .access_idx_i   (plru_idx),
        .victim_c       (repl_idx)
    );
`else
    logic [IDX_W-1:0] rr_q;

    // Advances only when a fill evicts a valid entry.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_q <= '0;
        end else if (fill && !free) begin
            rr_q <= rr_q + IDX_W'(1);
        end
    end

    assign repl_idx = rr_q;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (tlb_ptw_comm_i.req.valid) state_d = S_LOOKUP;
            S_LOOKUP:    state_d = hit ? S_RESP : S_MISS_REQ;
            S_MISS_REQ:  if (ptw_tlb_comm_i.ptw_ready) state_d = S_MISS_WAIT;
            S_MISS_WAIT: if (ptw_tlb_comm_i.resp.valid) state_d = S_RESP;
            S_RESP:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Flush is applied after the fill so a simultaneous flush leaves the entry invalid.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < L2TLB_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
            req_vpn_q       <= '0;
            resp_error_q    <= 1'b0;
            resp_level_q    <= '0;
            resp_pte_q      <= '0;
            flush_pending_q <= 1'b0;
            hit_pulse_q     <= 1'b0;
            miss_pulse_q    <= 1'b0;
        end else begin
            hit_pulse_q  <= lookup_hit;
            miss_pulse_q <= handshake;
            if (accept) begin
                req_vpn_q <= tlb_ptw_comm_i.req.vpn;
            end
            if (lookup_hit) begin
                resp_error_q <= 1'b0;
                resp_level_q <= entries_q[hit_idx].level;
                resp_pte_q   <= hit_pte;
            end
            if (resp_take) begin
                resp_error_q <= ptw_tlb_comm_i.resp.error;
                resp_level_q <= ptw_tlb_comm_i.resp.level;
                resp_pte_q   <= ptw_tlb_comm_i.resp.pte;
            end
            if (fill) begin
                entries_q[victim_idx] <= fill_entry;
            end
            if (flush) begin
                for (int unsigned i = 0; i < L2TLB_ENTRIES; i++) begin
                    entries_q[i].valid <= 1'b0;
                end
            end
            if (state_q == S_IDLE) begin
                flush_pending_q <= 1'b0;
            end else if (flush && ((state_q == S_MISS_REQ) || (state_q == S_MISS_WAIT))) begin
                flush_pending_q <= 1'b1;
            end
        end
    end

    always_comb begin
        ptw_tlb_comm_o                = '0;
        ptw_tlb_comm_o.resp.valid     = (state_q == S_RESP);
        ptw_tlb_comm_o.resp.error     = resp_error_q;
        ptw_tlb_comm_o.resp.level     = resp_level_q;
        ptw_tlb_comm_o.resp.pte       = resp_pte_q;
        ptw_tlb_comm_o.ptw_ready      = (state_q == S_IDLE);
        ptw_tlb_comm_o.ptw_status     = ptw_tlb_comm_i.ptw_status;
        ptw_tlb_comm_o.invalidate_tlb = ptw_tlb_comm_i.invalidate_tlb;
    end

    always_comb begin
        tlb_ptw_comm_o           = '0;
        tlb_ptw_comm_o.req.valid = (state_q == S_MISS_REQ);
        tlb_ptw_comm_o.req.vpn   = req_vpn_q;
    end

    assign pmu_l2tlb_hit_o  = hit_pulse_q;
    assign pmu_l2tlb_miss_o = miss_pulse_q;

endmodule

// File: tb/tb_l2_tlb.sv
// Scoreboard bench for l2_tlb: a scripted walker model answers misses, a monitor checks every response.
module tb_l2_tlb;
    import mmu_pkg::*;

    typedef struct {
        logic                hit;
        logic                error;
        logic [LEVEL_W-1:0]  level;
        logic [PPN_SIZE-1:0] ppn;
        logic [VPN_SIZE-1:0] vpn;
        int                  acc_cyc;
        int                  lat;
    } exp_t;

    localparam ptw_status_t STATUS = '{prv: 2'b01, sum: 1'b1, mxr: 1'b0, asid: 16'hBEEF};

    logic          clk_i = 1'b0;
    logic          rstn_i;
    tlb_ptw_comm_t tlb_req;
    ptw_tlb_comm_t dut_resp;
    tlb_ptw_comm_t walk_req;
    ptw_tlb_comm_t walk_resp;
    logic          pmu_hit;
    logic          pmu_miss;

    int                  n_checks = 0;
    int                  n_errors = 0;
    int                  cyc = 0;
    int                  walk_cnt = 0;
    int                  walk_base = 0;
    int                  miss_cnt = 0;
    int                  miss_base = 0;
    int                  resp_cnt = 0;
    exp_t                sb[$];
    exp_t                mon_e;
    int                  w_lat = 1;
    logic                w_err = 1'b0;
    logic [LEVEL_W-1:0]  w_lvl = '0;
    logic [PPN_SIZE-1:0] w_ppn = '0;
    logic                w_flush = 1'b0;
    logic [VPN_SIZE-1:0] w_last_vpn = '0;

    l2_tlb dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .tlb_ptw_comm_i   (tlb_req),
        .ptw_tlb_comm_o   (dut_resp),
        .tlb_ptw_comm_o   (walk_req),
        .ptw_tlb_comm_i   (walk_resp),
        .pmu_l2tlb_hit_o  (pmu_hit),
        .pmu_l2tlb_miss_o (pmu_miss)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Walker model: W edges after the handshake edge the response is captured by the DUT.
    initial begin
        pte_t p;
        forever begin
            @(negedge clk_i);
            if (rstn_i && walk_req.req.valid && walk_resp.ptw_ready) begin
                walk_cnt++;
                w_last_vpn = walk_req.req.vpn;
                @(posedge clk_i);
                for (int k = 1; k < w_lat; k++) begin
                    @(negedge clk_i);
                    walk_resp.invalidate_tlb = w_flush && (k == 1);
                    @(posedge clk_i);
                end
                @(negedge clk_i);
                walk_resp.invalidate_tlb = 1'b0;
                p = '0;
                p.ppn = w_ppn;
                p.v = 1'b1;
                p.r = 1'b1;
                p.a = 1'b1;
                walk_resp.resp.valid = 1'b1;
                walk_resp.resp.error = w_err;
                walk_resp.resp.level = w_lvl;
                walk_resp.resp.pte   = p;
                @(negedge clk_i);
                walk_resp.resp.valid = 1'b0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (pmu_miss) miss_cnt++;
        if (dut_resp.resp.valid) begin
            resp_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_error", dut_resp.resp.error, mon_e.error);
                check("resp_level", dut_resp.resp.level, mon_e.level);
                check("resp_ppn", dut_resp.resp.pte.ppn, mon_e.ppn);
                check("hit_pulse", pmu_hit, mon_e.hit);
                check("latency", cyc + 1 - mon_e.acc_cyc, mon_e.lat);
                check("walks", walk_cnt - walk_base, mon_e.hit ? 0 : 1);
                check("miss_pulses", miss_cnt - miss_base, mon_e.hit ? 0 : 1);
                if (!mon_e.hit) check("walk_vpn", w_last_vpn, mon_e.vpn);
                walk_base = walk_cnt;
                miss_base = miss_cnt;
            end
        end
    end

    // Issue one request from a negedge and wait for its response to be scored.
    task automatic issue(input logic [VPN_SIZE-1:0] vpn, input logic hit, input logic err,
                         input logic [LEVEL_W-1:0] lvl, input logic [PPN_SIZE-1:0] ppn,
                         input int wl);
        exp_t e;
        int   t;
        t = 0;
        while (!dut_resp.ptw_ready && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 100) check("ready_timeout", 0, 1);
        w_lat = wl;
        w_err = err;
        w_lvl = lvl;
        w_ppn = ppn;
        e = '{hit, err, lvl, ppn, vpn, cyc + 1, hit ? 2 : wl + 3};
        sb.push_back(e);
        tlb_req.req.valid = 1'b1;
        tlb_req.req.vpn   = vpn;
        @(negedge clk_i);
        tlb_req.req.valid = 1'b0;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        if (sb.size() != 0) begin
            check("resp_timeout", 0, 1);
            sb.delete();
        end
    endtask

    task automatic flush_idle();
        walk_resp.invalidate_tlb = 1'b1;
        #1;
        check("inv_passthrough", dut_resp.invalidate_tlb, 1);
        @(negedge clk_i);
        walk_resp.invalidate_tlb = 1'b0;
    endtask

    initial begin
        int rc_base;
        int wc_base;
        tlb_req   = '0;
        walk_resp = '0;
        walk_resp.ptw_ready  = 1'b1;
        walk_resp.ptw_status = STATUS;
        rstn_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_ptw_ready", dut_resp.ptw_ready, 1);
        check("rst_resp_valid", dut_resp.resp.valid, 0);
        check("rst_walk_valid", walk_req.req.valid, 0);
        check("rst_pmu_hit", pmu_hit, 0);
        check("rst_pmu_miss", pmu_miss, 0);
        rstn_i = 1'b1;
        @(negedge clk_i);
        check("status_passthrough", dut_resp.ptw_status, STATUS);

        // Cold miss then hit on a 4 KiB page
        issue(27'h12345, 1'b0, 1'b0, 2'd2, 44'hABCDE, 4);
        issue(27'h12345, 1'b1, 1'b0, 2'd2, 44'hABCDE, 4);

        // 2 MiB superpage: fill from vpn 0x200, hit from 0x3FF in the same region
        issue(27'h00200, 1'b0, 1'b0, 2'd1, 44'h40000, 2);
        issue(27'h003FF, 1'b1, 1'b0, 2'd1, 44'h401FF, 2);

        // Error responses are forwarded and never cached
        issue(27'h00777, 1'b0, 1'b1, 2'd2, 44'h11111, 3);
        issue(27'h00777, 1'b0, 1'b1, 2'd2, 44'h11111, 3);

        // Flush while idle drops everything
        flush_idle();
        issue(27'h12345, 1'b0, 1'b0, 2'd2, 44'hABCDE, 1);
        issue(27'h003FF, 1'b0, 1'b0, 2'd2, 44'h22222, 1);
        issue(27'h12345, 1'b1, 1'b0, 2'd2, 44'hABCDE, 1);

        // Flush during the walk: response forwarded, not cached
        w_flush = 1'b1;
        issue(27'h00555, 1'b0, 1'b0, 2'd2, 44'h55555, 4);
        w_flush = 1'b0;
        issue(27'h00555, 1'b0, 1'b0, 2'd2, 44'h55555, 1);
        issue(27'h00555, 1'b1, 1'b0, 2'd2, 44'h55555, 1);

        // Capacity: 16 sequential fills, then a 17th evicts entry 0 (vpn 0x100)
        flush_idle();
        for (int i = 0; i < 16; i++)
            issue(27'h100 + 27'(i), 1'b0, 1'b0, 2'd2, 44'h1000 + 44'(i), 1);
        issue(27'h999, 1'b0, 1'b0, 2'd2, 44'h9999, 1);
        for (int i = 1; i < 16; i++)
            issue(27'h100 + 27'(i), 1'b1, 1'b0, 2'd2, 44'h1000 + 44'(i), 1);
        issue(27'h999, 1'b1, 1'b0, 2'd2, 44'h9999, 1);
        issue(27'h100, 1'b0, 1'b0, 2'd2, 44'h1000, 1);

        // Reset while the walker request is pending
        walk_resp.ptw_ready = 1'b0;
        rc_base = resp_cnt;
        wc_base = walk_cnt;
        while (!dut_resp.ptw_ready) @(negedge clk_i);
        tlb_req.req.valid = 1'b1;
        tlb_req.req.vpn   = 27'h666;
        @(negedge clk_i);
        tlb_req.req.valid = 1'b0;
        @(negedge clk_i);
        check("missreq_valid", walk_req.req.valid, 1);
        check("missreq_vpn", walk_req.req.vpn, 27'h666);
        #2 rstn_i = 1'b0;
        #1;
        check("arst_walk_valid", walk_req.req.valid, 0);
        check("arst_ptw_ready", dut_resp.ptw_ready, 1);
        check("arst_resp_valid", dut_resp.resp.valid, 0);
        check("arst_pmu_hit", pmu_hit, 0);
        check("arst_pmu_miss", pmu_miss, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        walk_resp.ptw_ready = 1'b1;
        repeat (10) @(negedge clk_i);
        check("no_resp_after_rst", resp_cnt - rc_base, 0);
        check("no_walk_after_rst", walk_cnt - wc_base, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        check("watchdog", 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
